fc_layer_link: RTL
==================

Name: fc_layer_link

Overview:
- Inter-layer glue between two fc_layer instances of an MLP top: consumes the activated output stream (o_func_data) of layer n and writes it into the input buffer of layer n+1.
- Counts elements into consecutive ibuf addresses and applies upstream backpressure while the downstream layer is full or computing.
- Issues the downstream start pulse once a full input vector is written and the downstream layer is idle.
- One instance sits between each adjacent layer pair (e.g. between layer 1 and layer 2).

Parameters:
- datatype_size, 8, element width of the downstream ibuf (o_ibuf_wr_data).
- output_datatype_size, 8, element width of the upstream stream (i_up_data); must be >= datatype_size.
- input_size, 784, downstream layer input size; equals the upstream output size; elements per vector.
- addr_w, $clog2(input_size), ibuf address width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_up_valid  in  1  upstream element valid.
- i_up_data  in  output_datatype_size  upstream element, unsigned.
- o_up_stall  out  1  backpressure; upstream holds data while high; feeds the upstream layer's i_next_busy.
- o_ibuf_we  out  1  downstream ibuf write enable (i_ibuf_we).
- o_ibuf_wr_data  out  datatype_size  downstream ibuf write data.
- o_ibuf_addr  out  addr_w  downstream ibuf address.
- o_start  out  1  one-cycle start pulse to the downstream layer (i_start).
- i_dn_busy  in  1  downstream layer o_busy.
- o_vec_count  out  16  completed vectors handed downstream; wraps at 2^16.

Behaviour:
- Reset (async, any state): state=FILL, element counter=0, vec_count=0. All outputs 0: o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr, o_start. o_up_stall=0.
- States: FILL, WAIT_IDLE, START, ARMED, DRAIN.
- o_up_stall is combinational from state: 0 in FILL, 1 in every other state.
- Element acceptance happens only when state==FILL and i_up_valid==1.
- On acceptance, the next cycle drives o_ibuf_we=1, o_ibuf_addr=cnt, o_ibuf_wr_data=sat(i_up_data). Latency is 1 cycle; all write outputs are registered.
- sat(): if i_up_data > 2^datatype_size-1, the result is 2^datatype_size-1; otherwise the low datatype_size bits.
- When o_ibuf_we is 0, o_ibuf_addr and o_ibuf_wr_data hold their last values.
- cnt increments per acceptance. An acceptance with cnt==input_size-1 sets cnt=0 and moves to WAIT_IDLE. Back-to-back valid fills a vector in input_size cycles.
- WAIT_IDLE -> START when i_dn_busy==0. Because the last write is registered, START is reached no earlier than the cycle after the final o_ibuf_we.
- START: o_start=1 for exactly one cycle; vec_count increments; go to ARMED.
- ARMED -> DRAIN when i_dn_busy==1. If i_dn_busy is still 0 after 2 cycles in ARMED, go to DRAIN anyway (covers a downstream layer that completes instantly).
- DRAIN -> FILL when i_dn_busy==0. This guarantees the ibuf is not overwritten while downstream is computing.
- i_up_valid while stalled: ignored, no write, no count change.
- i_dn_busy toggling during FILL: no effect.
- Reset mid-vector: partial vector discarded, counter restarts at address 0, no o_start is issued.
- input_size==1: every accepted element completes a vector.

Decomposition:
- Shared package cim_pkg (add to the existing one): link_state_t enum {FILL, WAIT_IDLE, START, ARMED, DRAIN}; constant LINK_ARM_TIMEOUT=2; function sat_trunc(value, out_width).
- Optional sub-module fc_link_sat, a combinational saturating narrower. Otherwise the block is single-module RTL.

Test Plan:
- Fill, input_size=4, back-to-back valid with data 10,20,30,40, i_dn_busy=0 -> writes at addr 0..3 on cycles 1..4 after the first valid; o_start pulses on cycle 6; o_vec_count=1.
- Backpressure: after the vector, hold i_dn_busy=1 for 20 cycles with i_up_valid=1 -> o_up_stall=1, no o_ibuf_we, no o_start. Release busy -> o_start one cycle later, then ARMED/DRAIN, then FILL resumes at addr 0.
- Saturation: output_datatype_size=12, datatype_size=8, data 0x0FF and 0x100 and 0xABC -> wr_data 0xFF, 0xFF, 0xFF; data 0x07F -> 0x7F.
- Gapped valid: valid every 3rd cycle, input_size=5 -> addresses 0..4 in order, exactly 5 writes, 1 start.
- Async reset asserted mid-vector after 2 writes, between clock edges -> outputs 0 immediately; next vector writes start at addr 0; o_vec_count=0.
- ARMED timeout: i_dn_busy held 0 throughout -> DRAIN entered 2 cycles after o_start, FILL 1 cycle later; 3 consecutive vectors give o_vec_count=3.

Source files
------------

// File: rtl/cim_pkg.sv
// cim_pkg: shared types, constants and helpers for the CIM MLP blocks
package cim_pkg;
  typedef enum logic [2:0] {FILL, WAIT_IDLE, START, ARMED, DRAIN} link_state_t;
  localparam int LINK_ARM_TIMEOUT = 2;
  function automatic logic [31:0] sat_trunc(input logic [31:0] value, input int out_width);
    logic [31:0] max_v;
    max_v = out_width >= 32 ? '1 : (32'd1 << out_width) - 32'd1;
    return value > max_v ? max_v : value;
  endfunction
endpackage

// File: rtl/fc_link_sat.sv
// fc_link_sat: combinational unsigned saturating narrower
module fc_link_sat
  import cim_pkg::*;
#(
  parameter int in_w  = 12,
  parameter int out_w = 8
) (
  input  logic [in_w-1:0]  a,
  output logic [out_w-1:0] y
);
  assign y = out_w'(sat_trunc(32'(a), out_w));
endmodule

// File: rtl/fc_layer_link.sv
// fc_layer_link: streams one layer's activations into the next layer's ibuf and starts it
module fc_layer_link
  import cim_pkg::*;
#(
  parameter int datatype_size        = 8,
  parameter int output_datatype_size = 8,
  parameter int input_size           = 784,
  parameter int addr_w               = input_size > 1 ? $clog2(input_size) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_up_valid,
  input  logic [output_datatype_size-1:0] i_up_data,
  output logic                            o_up_stall,
  output logic                            o_ibuf_we,
  output logic [datatype_size-1:0]        o_ibuf_wr_data,
  output logic [addr_w-1:0]               o_ibuf_addr,
  output logic                            o_start,
  input  logic                            i_dn_busy,
  output logic [15:0]                     o_vec_count
);
  localparam logic [addr_w-1:0] last = addr_w'(input_size - 1);
  link_state_t state;
  logic [addr_w-1:0] cnt;
  logic [1:0] arm_cnt;
  logic [datatype_size-1:0] sat_data;
  logic accept;
  fc_link_sat #(.in_w(output_datatype_size), .out_w(datatype_size)) u_sat (
    .a(i_up_data),
    .y(sat_data)
  );
  assign accept = state == FILL && i_up_valid;
  assign o_up_stall = state != FILL;
  // handshake FSM with registered ibuf write port and start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt <= '0;
      arm_cnt <= '0;
      o_ibuf_we <= 1'b0;
      o_ibuf_wr_data <= '0;
      o_ibuf_addr <= '0;
      o_start <= 1'b0;
      o_vec_count <= '0;
    end else begin
      o_ibuf_we <= accept;
      o_start <= 1'b0;
      if (accept) begin
        o_ibuf_addr <= cnt;
        o_ibuf_wr_data <= sat_data;
        cnt <= cnt == last ? '0 : cnt + addr_w'(1);
      end
      case (state)
        FILL: if (accept && cnt == last) state <= WAIT_IDLE;
        WAIT_IDLE: if (!i_dn_busy) state <= START;
        START: begin
          o_start <= 1'b1;
          o_vec_count <= o_vec_count + 16'd1;
          arm_cnt <= '0;
          state <= ARMED;
        end
        ARMED: begin
          arm_cnt <= arm_cnt + 2'd1;
          if (i_dn_busy || arm_cnt == 2'(LINK_ARM_TIMEOUT - 1)) state <= DRAIN;
        end
        DRAIN: if (!i_dn_busy) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end
endmodule
